sn_prot_regs: RTL and testbench

SN_PROT_REGS -- requirements
Module: sn_prot_regs

---
 rtl/sn_pkg.sv | 25 ++
 rtl/sn_run_ctrl.sv | 77 +++++++
 rtl/sn_prot_regs.sv | 124 ++++++++++++
 tb/tb_sn_prot_regs.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sn_pkg.sv
// rtl/sn_pkg.sv - shared register map and run-state definitions for the protocol register block
package sn_pkg;

  localparam logic [6:0] ADDR_START       = 7'd0;
  localparam logic [6:0] ADDR_CUR_TS_MSB  = 7'd1;
  localparam logic [6:0] ADDR_CUR_TS_LSB  = 7'd2;
  localparam logic [6:0] ADDR_MAX_TS_MSB  = 7'd3;
  localparam logic [6:0] ADDR_MAX_TS_LSB  = 7'd4;
  localparam logic [6:0] ADDR_IN_WRITE    = 7'd5;
  localparam logic [6:0] ADDR_IN_ADDR_MSB = 7'd6;
  localparam logic [6:0] ADDR_IN_ADDR_LSB = 7'd7;
  localparam logic [6:0] ADDR_IN_DATA2    = 7'd9;
  localparam logic [6:0] ADDR_IN_DATA1    = 7'd10;
  localparam logic [6:0] ADDR_IN_DATA0    = 7'd11;
  localparam logic [6:0] ADDR_OUT_SEL     = 7'd12;
  localparam logic [6:0] ADDR_OUT_CNT     = 7'd13;

  typedef enum logic [1:0] {
    RUN_IDLE  = 2'd0,
    RUN_CLEAR = 2'd1,
    RUN_STEP  = 2'd2,
    RUN_WAIT  = 2'd3
  } run_state_t;

endpackage

// File: rtl/sn_run_ctrl.sv
// rtl/sn_run_ctrl.sv - run sequencer: clear pulse, then step/wait handshake until max timestep
module sn_run_ctrl
  import sn_pkg::*;
#(
  parameter int P_TS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_set,
  input  logic              start_abort,
  input  logic [P_TS_W-1:0] max_ts_in,
  input  logic              net_step_done,
  output logic              busy,
  output logic [P_TS_W-1:0] cur_ts,
  output logic              net_clear,
  output logic              net_step
);

  run_state_t        state;
  logic [P_TS_W-1:0] max_ts;
  logic [P_TS_W-1:0] cur_ts_inc;

  assign cur_ts_inc = cur_ts + P_TS_W'(1);
  assign busy       = (state != RUN_IDLE);

  // Run FSM with registered pulses; an abort wins over every other transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN_IDLE;
      cur_ts    <= '0;
      max_ts    <= '0;
      net_clear <= 1'b0;
      net_step  <= 1'b0;
    end else begin
      net_clear <= 1'b0;
      net_step  <= 1'b0;
      if (start_abort && state != RUN_IDLE) begin
        state <= RUN_IDLE;
      end else begin
        case (state)
          RUN_IDLE: begin
            if (start_set) begin
              state     <= RUN_CLEAR;
              net_clear <= 1'b1;
              max_ts    <= max_ts_in;
              cur_ts    <= '0;
            end
          end
          RUN_CLEAR: begin
            if (max_ts == '0) begin
              state <= RUN_IDLE;
            end else begin
              state    <= RUN_STEP;
              net_step <= 1'b1;
            end
          end
          RUN_STEP: begin
            state <= RUN_WAIT;
          end
          RUN_WAIT: begin
            if (net_step_done) begin
              cur_ts <= cur_ts_inc;
              if (cur_ts_inc == max_ts) begin
                state <= RUN_IDLE;
              end else begin
                state    <= RUN_STEP;
                net_step <= 1'b1;
              end
            end
          end
          default: state <= RUN_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sn_prot_regs.sv
// rtl/sn_prot_regs.sv - byte-wide register front end driving network input writes and timestep runs
module sn_prot_regs
  import sn_pkg::*;
#(
  parameter int P_NUM_INPUTS  = 23,
  parameter int P_NUM_OUTPUTS = 3,
  parameter int P_TS_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prot_enable,
  input  logic        prot_r0w1,
  input  logic [6:0]  prot_addr,
  input  logic [7:0]  prot_wdata,
  output logic [7:0]  prot_rdata,
  output logic        in_wr_en,
  output logic [15:0] in_wr_addr,
  output logic [23:0] in_wr_data,
  output logic        net_clear,
  output logic        net_step,
  input  logic        net_step_done,
  output logic [7:0]  cnt_sel,
  input  logic [7:0]  cnt_value
);

  // Input index is carried on 16 bits and the counter select on 8 bits
  if (P_NUM_INPUTS > 65536 || P_NUM_OUTPUTS > 256 || P_TS_W < 1) begin : g_param_check
    $error("sn_prot_regs: parameter out of range");
  end

  logic [7:0]        max_ts_msb;
  logic [7:0]        max_ts_lsb;
  logic [7:0]        in_addr_msb;
  logic [7:0]        in_addr_lsb;
  logic [7:0]        in_data2;
  logic [7:0]        in_data1;
  logic [7:0]        in_data0;
  logic [7:0]        out_sel;
  logic              wr;
  logic              rd;
  logic              start_set;
  logic              start_abort;
  logic              busy;
  logic [P_TS_W-1:0] cur_ts;
  logic [15:0]       cur_ts16;

  assign wr          = prot_enable & prot_r0w1;
  assign rd          = prot_enable & ~prot_r0w1;
  assign start_set   = wr && (prot_addr == ADDR_START) && prot_wdata[0];
  assign start_abort = wr && (prot_addr == ADDR_START) && !prot_wdata[0];
  assign cur_ts16    = 16'(cur_ts);

  assign in_wr_addr  = {in_addr_msb, in_addr_lsb};
  assign in_wr_data  = {in_data2, in_data1, in_data0};
  assign cnt_sel     = out_sel;

  sn_run_ctrl #(
    .P_TS_W(P_TS_W)
  ) u_run_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start_set    (start_set),
    .start_abort  (start_abort),
    .max_ts_in    (P_TS_W'({max_ts_msb, max_ts_lsb})),
    .net_step_done(net_step_done),
    .busy         (busy),
    .cur_ts       (cur_ts),
    .net_clear    (net_clear),
    .net_step     (net_step)
  );

  // RW register writes and the input-write strobe, which is held off during a run
  always_ff @(posedge clk) begin
    if (rst) begin
      max_ts_msb  <= '0;
      max_ts_lsb  <= '0;
      in_addr_msb <= '0;
      in_addr_lsb <= '0;
      in_data2    <= '0;
      in_data1    <= '0;
      in_data0    <= '0;
      out_sel     <= '0;
      in_wr_en    <= 1'b0;
    end else begin
      in_wr_en <= wr && (prot_addr == ADDR_IN_WRITE) && prot_wdata[0] && !busy;
      if (wr) begin
        case (prot_addr)
          ADDR_MAX_TS_MSB:  max_ts_msb  <= prot_wdata;
          ADDR_MAX_TS_LSB:  max_ts_lsb  <= prot_wdata;
          ADDR_IN_ADDR_MSB: in_addr_msb <= prot_wdata;
          ADDR_IN_ADDR_LSB: in_addr_lsb <= prot_wdata;
          ADDR_IN_DATA2:    in_data2    <= prot_wdata;
          ADDR_IN_DATA1:    in_data1    <= prot_wdata;
          ADDR_IN_DATA0:    in_data0    <= prot_wdata;
          ADDR_OUT_SEL:     out_sel     <= prot_wdata;
          default: ;
        endcase
      end
    end
  end

  // Zero-latency read mux; anything but an enabled read returns 0
  always_comb begin
    prot_rdata = 8'd0;
    if (rd) begin
      case (prot_addr)
        ADDR_START:       prot_rdata = {7'd0, busy};
        ADDR_CUR_TS_MSB:  prot_rdata = cur_ts16[15:8];
        ADDR_CUR_TS_LSB:  prot_rdata = cur_ts16[7:0];
        ADDR_MAX_TS_MSB:  prot_rdata = max_ts_msb;
        ADDR_MAX_TS_LSB:  prot_rdata = max_ts_lsb;
        ADDR_IN_ADDR_MSB: prot_rdata = in_addr_msb;
        ADDR_IN_ADDR_LSB: prot_rdata = in_addr_lsb;
        ADDR_IN_DATA2:    prot_rdata = in_data2;
        ADDR_IN_DATA1:    prot_rdata = in_data1;
        ADDR_IN_DATA0:    prot_rdata = in_data0;
        ADDR_OUT_SEL:     prot_rdata = out_sel;
        ADDR_OUT_CNT:     prot_rdata = cnt_value;
        default:          prot_rdata = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sn_prot_regs.sv
// tb/tb_sn_prot_regs.sv - self-checking bench for sn_prot_regs
module tb_sn_prot_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        prot_enable;
  logic        prot_r0w1;
  logic [6:0]  prot_addr;
  logic [7:0]  prot_wdata;
  logic [7:0]  prot_rdata;
  logic        in_wr_en;
  logic [15:0] in_wr_addr;
  logic [23:0] in_wr_data;
  logic        net_clear;
  logic        net_step;
  logic        net_step_done;
  logic [7:0]  cnt_sel;
  logic [7:0]  cnt_value;

  always #5 clk = ~clk;

  sn_prot_regs dut (
    .clk          (clk),
    .rst          (rst),
    .prot_enable  (prot_enable),
    .prot_r0w1    (prot_r0w1),
    .prot_addr    (prot_addr),
    .prot_wdata   (prot_wdata),
    .prot_rdata   (prot_rdata),
    .in_wr_en     (in_wr_en),
    .in_wr_addr   (in_wr_addr),
    .in_wr_data   (in_wr_data),
    .net_clear    (net_clear),
    .net_step     (net_step),
    .net_step_done(net_step_done),
    .cnt_sel      (cnt_sel),
    .cnt_value    (cnt_value)
  );

  int total = 0;
  int bad   = 0;
  int n_clr, n_step, n_wr, n_done, pend;
  bit auto_done;

  // Reference model: register contents plus run phase flags
  logic [7:0] mreg [0:15];
  bit m_busy, m_clr, m_stp, m_wait, m_wren;
  int m_cur, m_max;

  typedef struct {
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, count pulses, and optionally answer each step after 2 cycles
  task automatic cyc();
    @(negedge clk);
    if (net_clear) n_clr++;
    if (net_step)  n_step++;
    if (in_wr_en)  n_wr++;
    if (auto_done) begin
      net_step_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          net_step_done = 1'b1;
          n_done++;
        end
      end
      if (net_step) pend = 2;
    end
  endtask

  task automatic clr_counts();
    n_clr = 0; n_step = 0; n_wr = 0; n_done = 0; pend = 0;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    prot_enable = 1'b1; prot_r0w1 = 1'b1; prot_addr = a; prot_wdata = d;
    cyc();
    prot_enable = 1'b0; prot_r0w1 = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
    prot_enable = 1'b1; prot_r0w1 = 1'b0; prot_addr = a;
    #1;
    d = prot_rdata;
    prot_enable = 1'b0;
  endtask

  function automatic logic [7:0] mread(input int a);
    case (a)
      0: return 8'(m_busy);
      1: return 8'((m_cur >> 8) & 255);
      2: return 8'(m_cur & 255);
      3, 4, 6, 7, 9, 10, 11, 12: return mreg[a];
      13: return cnt_value;
      default: return 8'd0;
    endcase
  endfunction

  function automatic void model_step(input bit do_wr, input int a, input logic [7:0] d, input bit done);
    m_wren = do_wr && a == 5 && d[0] && !m_busy;
    if (do_wr && a == 0 && !d[0] && m_busy) begin
      m_busy = 0; m_clr = 0; m_stp = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (do_wr && a == 0 && d[0]) begin
        m_busy = 1; m_clr = 1;
        m_max = int'(mreg[3]) * 256 + int'(mreg[4]);
        m_cur = 0;
      end
    end else if (m_clr) begin
      m_clr = 0;
      if (m_max == 0) m_busy = 0;
      else m_stp = 1;
    end else if (m_stp) begin
      m_stp = 0; m_wait = 1;
    end else if (m_wait && done) begin
      m_cur = (m_cur + 1) & 16'hFFFF;
      m_wait = 0;
      if (m_cur == m_max) m_busy = 0;
      else m_stp = 1;
    end
    if (do_wr && (a inside {3, 4, 6, 7, 9, 10, 11, 12})) mreg[a] = d;
  endfunction

  initial begin
    logic [7:0] rd;
    logic [7:0] c0;
    int s0;
    bit ended;
    int wr_addrs [16] = '{0, 0, 0, 3, 4, 4, 5, 5, 6, 7, 9, 10, 11, 12, 8, 13};

    rst = 1'b1; prot_enable = 0; prot_r0w1 = 0; prot_addr = 0; prot_wdata = 0;
    net_step_done = 0; cnt_value = 0; auto_done = 0;
    clr_counts();
    repeat (3) cyc();
    check("rst net_clear", net_clear, 0);
    check("rst net_step", net_step, 0);
    check("rst in_wr_en", in_wr_en, 0);
    rst = 1'b0;
    cyc();
    for (int a = 0; a < 14; a++) begin
      bus_read(7'(a), rd);
      check($sformatf("rst read a%0d", a), rd, 0);
    end

    // Register write/readback table
    tv[0]  = '{7'd3,   8'hA5, 8'hA5};
    tv[1]  = '{7'd4,   8'h5A, 8'h5A};
    tv[2]  = '{7'd6,   8'h00, 8'h00};
    tv[3]  = '{7'd7,   8'h05, 8'h05};
    tv[4]  = '{7'd9,   8'h12, 8'h12};
    tv[5]  = '{7'd10,  8'h34, 8'h34};
    tv[6]  = '{7'd11,  8'h56, 8'h56};
    tv[7]  = '{7'd12,  8'h02, 8'h02};
    tv[8]  = '{7'd1,   8'hFF, 8'h00};
    tv[9]  = '{7'd2,   8'hFF, 8'h00};
    tv[10] = '{7'd5,   8'h00, 8'h00};
    tv[11] = '{7'd8,   8'hFF, 8'h00};
    tv[12] = '{7'd14,  8'hFF, 8'h00};
    tv[13] = '{7'd127, 8'hAB, 8'h00};
    clr_counts();
    for (int i = 0; i < 14; i++) begin
      bus_write(tv[i].addr, tv[i].wdata);
      bus_read(tv[i].addr, rd);
      check($sformatf("tbl a%0d", tv[i].addr), rd, tv[i].exp);
    end
    check("tbl no wr_en", n_wr, 0);

    // Input-current write strobe
    bus_write(7'd5, 8'h01);
    check("inwr en", in_wr_en, 1);
    check("inwr addr", in_wr_addr, 16'h0005);
    check("inwr data", in_wr_data, 24'h123456);
    cyc();
    check("inwr en off", in_wr_en, 0);
    check("inwr once", n_wr, 1);
    check("inwr addr hold", in_wr_addr, 16'h0005);

    // Output counter select and read gating
    cnt_value = 8'h9A;
    bus_read(7'd13, rd);
    check("cnt_sel", cnt_sel, 8'd2);
    check("out_cnt", rd, 8'h9A);
    bus_read(7'd8, rd);
    check("addr8", rd, 8'h00);
    prot_enable = 0; prot_r0w1 = 0; prot_addr = 7'd13; #1;
    check("rdata disabled", prot_rdata, 0);
    prot_enable = 1; prot_r0w1 = 1; #1;
    check("rdata on write", prot_rdata, 0);
    prot_enable = 0; prot_r0w1 = 0;

    // Three-step run
    bus_write(7'd3, 8'h00);
    bus_write(7'd4, 8'h03);
    clr_counts(); auto_done = 1;
    bus_write(7'd0, 8'h01);
    bus_read(7'd0, rd);
    check("run3 start busy", rd, 1);
    ended = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      bus_read(7'd0, rd);
      if (rd == 0) begin ended = 1; break; end
    end
    auto_done = 0; net_step_done = 0;
    check("run3 ended", ended, 1);
    check("run3 done at idle", n_done, 3);
    check("run3 clears", n_clr, 1);
    check("run3 steps", n_step, 3);
    bus_read(7'd1, rd); check("run3 cur msb", rd, 0);
    bus_read(7'd2, rd); check("run3 cur lsb", rd, 3);

    // Zero-length run
    bus_write(7'd4, 8'h00);
    clr_counts();
    bus_write(7'd0, 8'h01);
    bus_read(7'd0, rd);
    check("run0 busy", rd, 1);
    check("run0 clear", n_clr, 1);
    cyc();
    bus_read(7'd0, rd);
    check("run0 idle", rd, 0);
    repeat (4) cyc();
    check("run0 no step", n_step, 0);
    check("run0 one clear", n_clr, 1);

    // Abort mid-run; input write suppressed while running
    bus_write(7'd4, 8'h05);
    clr_counts(); auto_done = 1;
    bus_write(7'd0, 8'h01);
    for (int i = 0; i < 50 && n_step < 2; i++) cyc();
    check("abort reached step2", n_step >= 2, 1);
    bus_write(7'd5, 8'h01);
    cyc();
    check("abort no wr_en", n_wr, 0);
    bus_read(7'd2, c0);
    s0 = n_step;
    bus_write(7'd0, 8'h00);
    bus_read(7'd0, rd);
    check("abort idle", rd, 0);
    repeat (10) cyc();
    auto_done = 0; net_step_done = 0;
    check("abort no more step", n_step, s0);
    bus_read(7'd2, rd);
    check("abort cur hold", rd, c0);
    check("abort no wr_en late", n_wr, 0);

    // Reset during WAIT
    clr_counts();
    bus_write(7'd0, 8'h01);
    for (int i = 0; i < 20 && n_step < 1; i++) cyc();
    check("rstwait step seen", n_step, 1);
    cyc();
    rst = 1;
    cyc();
    check("rstwait clear", net_clear, 0);
    check("rstwait step", net_step, 0);
    check("rstwait wr_en", in_wr_en, 0);
    bus_read(7'd0, rd);
    check("rstwait start", rd, 0);
    rst = 0;
    clr_counts();
    net_step_done = 1;
    cyc();
    net_step_done = 0;
    repeat (5) cyc();
    check("rstwait late step", n_step, 0);
    check("rstwait late clear", n_clr, 0);
    bus_read(7'd0, rd); check("rstwait start idle", rd, 0);
    bus_read(7'd2, rd); check("rstwait cur", rd, 0);
    bus_read(7'd4, rd); check("rstwait max reg", rd, 0);

    // Randomised traffic against the model
    rst = 1; cyc(); rst = 0; cyc();
    for (int i = 0; i < 16; i++) mreg[i] = 8'd0;
    m_busy = 0; m_clr = 0; m_stp = 0; m_wait = 0; m_wren = 0; m_cur = 0; m_max = 0;
    for (int k = 0; k < 3000; k++) begin
      int op, a;
      bit do_wr, dn;
      logic [7:0] d;
      check("rnd clear", net_clear, m_clr);
      check("rnd step", net_step, m_stp);
      check("rnd wr_en", in_wr_en, m_wren);
      check("rnd wr_addr", in_wr_addr, {mreg[6], mreg[7]});
      check("rnd wr_data", in_wr_data, {mreg[9], mreg[10], mreg[11]});
      cnt_value = 8'($urandom);
      op = int'($urandom_range(0, 99));
      do_wr = 0; a = 0; d = 0;
      if (op < 30) begin
        a = int'($urandom_range(0, 15));
        bus_read(7'(a), rd);
        check($sformatf("rnd read a%0d", a), rd, mread(a));
      end else if (op < 60) begin
        do_wr = 1;
        a = wr_addrs[$urandom_range(0, 15)];
        d = 8'($urandom);
        if (a == 3) d = 8'd0;
        if (a == 4) d = 8'($urandom_range(0, 4));
        if (a == 0) d[0] = ($urandom_range(0, 4) != 0);
      end
      dn = ($urandom_range(0, 2) == 0);
      net_step_done = dn;
      model_step(do_wr, a, d, dn);
      if (do_wr) begin
        prot_enable = 1; prot_r0w1 = 1; prot_addr = 7'(a); prot_wdata = d;
      end
      cyc();
      prot_enable = 0; prot_r0w1 = 0;
    end
    net_step_done = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
